mem_bus_ctrl: RTL and testbench

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_bus_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: turns single-cycle CPU read/write strobes into a held mem_req/mem_ack handshake.
// Optional macro MEM_ALIGN_CHECK_EN: when defined, a word access at an odd address faults instead of being forced even.
module mem_bus_ctrl #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] MAB_in,
    input  logic [15:0] MDB_out,
    input  logic        BW,
    input  logic        MEM_RD,
    input  logic        MEM_WR,
    output logic        BUSY,
    output logic [15:0] MDB_in,
    output logic        DONE,
    output logic        ERR,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_be,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    // Counter value seen during the last REQ cycle allowed before timeout.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    logic [1:0]  state_reg,    state_next;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;
    logic [15:0] addr_reg,     addr_next;
    logic [15:0] wdata_reg,    wdata_next;
    logic [1:0]  be_reg,       be_next;
    logic        we_reg,       we_next;
    logic        byte_reg,     byte_next;
    logic        hi_lane_reg,  hi_lane_next;
    logic [15:0] rdata_reg,    rdata_next;
    logic        done_reg,     done_next;
    logic        err_reg,      err_next;

    logic [1:0]  be_sel;
    logic [15:0] wdata_sel;
    logic [7:0]  rd_byte;
    logic        start;
    logic        conflict;
    logic        misalign;

    // Per-lane enable and write data; byte writes replicate the low byte onto both lanes.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign be_sel[gi]           = ~BW | (MAB_in[0] == 1'(gi));
            assign wdata_sel[gi*8 +: 8] = BW ? MDB_out[7:0] : MDB_out[gi*8 +: 8];
        end
    endgenerate

    assign rd_byte  = hi_lane_reg ? mem_rdata[15:8] : mem_rdata[7:0];
    assign start    = MEM_RD | MEM_WR;
    assign conflict = MEM_RD & MEM_WR;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = ~BW & MAB_in[0];
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        be_next       = be_reg;
        we_next       = we_reg;
        byte_next     = byte_reg;
        hi_lane_next  = hi_lane_reg;
        rdata_next    = rdata_reg;
        done_next     = 1'b0;
        err_next      = 1'b0;

        case (state_reg)
            ST_REQ: begin
                // Ack has priority over a timeout expiring in the same cycle.
                if (mem_ack) begin
                    state_next = ST_FIN;
                    done_next  = 1'b1;
                    if (!we_reg) begin
                        rdata_next = byte_reg ? {8'h00, rd_byte} : mem_rdata;
                    end
                end else if (wait_cnt_reg >= WAIT_LAST) begin
                    state_next = ST_FIN;
                    done_next  = 1'b1;
                    err_next   = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end
            default: begin
                // IDLE and FIN both accept a new start; FIN otherwise falls back to IDLE.
                state_next = ST_IDLE;
                if (start) begin
                    addr_next    = {MAB_in[15:1], 1'b0};
                    wdata_next   = wdata_sel;
                    be_next      = be_sel;
                    we_next      = MEM_WR & ~MEM_RD;
                    byte_next    = BW;
                    hi_lane_next = MAB_in[0];
                    if (conflict || misalign) begin
                        state_next = ST_FIN;
                        done_next  = 1'b1;
                        err_next   = 1'b1;
                    end else begin
                        state_next    = ST_REQ;
                        wait_cnt_next = 8'd0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 8'd0;
            addr_reg     <= 16'h0000;
            wdata_reg    <= 16'h0000;
            be_reg       <= 2'b00;
            we_reg       <= 1'b0;
            byte_reg     <= 1'b0;
            hi_lane_reg  <= 1'b0;
            rdata_reg    <= 16'h0000;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            be_reg       <= be_next;
            we_reg       <= we_next;
            byte_reg     <= byte_next;
            hi_lane_reg  <= hi_lane_next;
            rdata_reg    <= rdata_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    // Request and busy decode straight from the state register so reset drops them at once.
    assign BUSY      = (state_reg == ST_REQ);
    assign mem_req   = (state_reg == ST_REQ);
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mem_be    = be_reg;
    assign MDB_in    = rdata_reg;
    assign DONE      = done_reg;
    assign ERR       = err_reg;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl, built with WAIT_MAX=4.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] MAB_in;
    logic [15:0] MDB_out;
    logic        BW;
    logic        MEM_RD;
    logic        MEM_WR;
    logic        BUSY;
    logic [15:0] MDB_in;
    logic        DONE;
    logic        ERR;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    int checks   = 0;
    int failures = 0;

    mem_bus_ctrl #(.WAIT_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .MAB_in    (MAB_in),
        .MDB_out   (MDB_out),
        .BW        (BW),
        .MEM_RD    (MEM_RD),
        .MEM_WR    (MEM_WR),
        .BUSY      (BUSY),
        .MDB_in    (MDB_in),
        .DONE      (DONE),
        .ERR       (ERR),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic rd, input logic wr, input logic bw,
                         input logic [15:0] addr, input logic [15:0] wd);
        MEM_RD  = rd;
        MEM_WR  = wr;
        BW      = bw;
        MAB_in  = addr;
        MDB_out = wd;
        tick();
        MEM_RD  = 1'b0;
        MEM_WR  = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        MAB_in    = 16'h0000;
        MDB_out   = 16'h0000;
        BW        = 1'b0;
        MEM_RD    = 1'b0;
        MEM_WR    = 1'b0;
        mem_rdata = 16'h0000;
        mem_ack   = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_busy",  {15'd0, BUSY},    16'd0);
        check("rst_done",  {15'd0, DONE},    16'd0);
        check("rst_err",   {15'd0, ERR},     16'd0);
        check("rst_req",   {15'd0, mem_req}, 16'd0);
        check("rst_we",    {15'd0, mem_we},  16'd0);
        check("rst_mdb",   MDB_in,           16'h0000);
        check("rst_addr",  mem_addr,         16'h0000);
        check("rst_wdata", mem_wdata,        16'h0000);
        check("rst_be",    {14'd0, mem_be},  16'd0);
        rst_n = 1'b1;
        tick();

        // Word read 0x0200, ack in second REQ cycle
        start(1'b1, 1'b0, 1'b0, 16'h0200, 16'h0000);
        check("wr_req1",  {15'd0, mem_req}, 16'd1);
        check("wr_busy",  {15'd0, BUSY},    16'd1);
        check("wr_addr",  mem_addr,         16'h0200);
        check("wr_be",    {14'd0, mem_be},  16'd3);
        check("wr_we",    {15'd0, mem_we},  16'd0);
        check("wr_done0", {15'd0, DONE},    16'd0);
        tick();
        check("wr_req2", {15'd0, mem_req}, 16'd1);
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        check("wr_done", {15'd0, DONE},    16'd1);
        check("wr_err",  {15'd0, ERR},     16'd0);
        check("wr_mdb",  MDB_in,           16'hBEEF);
        check("wr_req0", {15'd0, mem_req}, 16'd0);
        check("wr_busy0",{15'd0, BUSY},    16'd0);
        tick();
        check("wr_done_pulse", {15'd0, DONE}, 16'd0);
        $display("txn word_read 0x0200 MDB_in=%h", MDB_in);

        // Byte write 0x0301, MDB_out 0x12A5
        start(1'b0, 1'b1, 1'b1, 16'h0301, 16'h12A5);
        check("bw_addr",  mem_addr,         16'h0300);
        check("bw_be",    {14'd0, mem_be},  16'd2);
        check("bw_wdata", mem_wdata,        16'hA5A5);
        check("bw_we",    {15'd0, mem_we},  16'd1);
        check("bw_req",   {15'd0, mem_req}, 16'd1);
        mem_ack   = 1'b1;
        mem_rdata = 16'h5555;
        tick();
        mem_ack = 1'b0;
        check("bw_done", {15'd0, DONE}, 16'd1);
        check("bw_err",  {15'd0, ERR},  16'd0);
        check("bw_mdb",  MDB_in,        16'hBEEF);
        tick();
        $display("txn byte_write 0x0301 wdata=%h", mem_wdata);

        // Byte read 0x0301 (high lane) with ack in first REQ cycle
        start(1'b1, 1'b0, 1'b1, 16'h0301, 16'h0000);
        check("br_be", {14'd0, mem_be}, 16'd2);
        mem_ack   = 1'b1;
        mem_rdata = 16'h7F3C;
        tick();
        mem_ack = 1'b0;
        check("br_done", {15'd0, DONE}, 16'd1);
        check("br_mdb",  MDB_in,        16'h007F);
        $display("txn byte_read 0x0301 MDB_in=%h", MDB_in);

        // Back-to-back start from FIN: byte read 0x0300 (low lane)
        start(1'b1, 1'b0, 1'b1, 16'h0300, 16'h0000);
        check("b2b_req",  {15'd0, mem_req}, 16'd1);
        check("b2b_be",   {14'd0, mem_be},  16'd1);
        check("b2b_done", {15'd0, DONE},    16'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("b2b_mdb", MDB_in, 16'h003C);
        tick();
        $display("txn byte_read 0x0300 MDB_in=%h", MDB_in);

        // Timeout: word read with no ack, req for exactly 4 cycles
        start(1'b1, 1'b0, 1'b0, 16'h0400, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("to_req%0d", i), {15'd0, mem_req}, 16'd1);
            check($sformatf("to_done%0d", i), {15'd0, DONE}, 16'd0);
            tick();
        end
        check("to_req_end", {15'd0, mem_req}, 16'd0);
        check("to_done",    {15'd0, DONE},    16'd1);
        check("to_err",     {15'd0, ERR},     16'd1);
        check("to_mdb",     MDB_in,           16'h003C);
        tick();
        check("to_err_pulse", {15'd0, ERR}, 16'd0);
        $display("txn timeout 0x0400 ERR pulse seen");

        // Ack on the final timeout cycle wins
        start(1'b1, 1'b0, 1'b0, 16'h0500, 16'h0000);
        tick();
        tick();
        tick();
        check("ackl_req", {15'd0, mem_req}, 16'd1);
        mem_ack   = 1'b1;
        mem_rdata = 16'hC0DE;
        tick();
        mem_ack = 1'b0;
        check("ackl_done", {15'd0, DONE}, 16'd1);
        check("ackl_err",  {15'd0, ERR},  16'd0);
        check("ackl_mdb",  MDB_in,        16'hC0DE);
        tick();
        $display("txn late_ack 0x0500 MDB_in=%h", MDB_in);

        // Both strobes together: fault without a request
        start(1'b1, 1'b1, 1'b0, 16'h0600, 16'h1111);
        check("both_req",  {15'd0, mem_req}, 16'd0);
        check("both_done", {15'd0, DONE},    16'd1);
        check("both_err",  {15'd0, ERR},     16'd1);
        check("both_mdb",  MDB_in,           16'hC0DE);
        tick();
        $display("txn both_strobes ERR=1");

        // Strobes during REQ are ignored
        start(1'b1, 1'b0, 1'b0, 16'h0700, 16'h0000);
        MEM_WR = 1'b1;
        MAB_in = 16'h0800;
        tick();
        MEM_WR = 1'b0;
        check("ign_addr", mem_addr,        16'h0700);
        check("ign_we",   {15'd0, mem_we}, 16'd0);
        mem_ack   = 1'b1;
        mem_rdata = 16'h0A0B;
        tick();
        mem_ack = 1'b0;
        check("ign_mdb", MDB_in, 16'h0A0B);
        tick();
        check("ign_idle", {15'd0, mem_req}, 16'd0);
        $display("txn ignored_strobe 0x0700 MDB_in=%h", MDB_in);

        // Ack outside REQ is ignored
        mem_ack   = 1'b1;
        mem_rdata = 16'hFFFF;
        tick();
        tick();
        mem_ack = 1'b0;
        check("stray_done", {15'd0, DONE}, 16'd0);
        check("stray_mdb",  MDB_in,        16'h0A0B);
        $display("txn stray_ack no effect");

        // Odd word address
        start(1'b1, 1'b0, 1'b0, 16'h0203, 16'h0000);
`ifdef MEM_ALIGN_CHECK_EN
        check("odd_req",  {15'd0, mem_req}, 16'd0);
        check("odd_done", {15'd0, DONE},    16'd1);
        check("odd_err",  {15'd0, ERR},     16'd1);
`else
        check("odd_req",  {15'd0, mem_req}, 16'd1);
        check("odd_addr", mem_addr,         16'h0202);
        check("odd_be",   {14'd0, mem_be},  16'd3);
        mem_ack   = 1'b1;
        mem_rdata = 16'h2345;
        tick();
        mem_ack = 1'b0;
        check("odd_done", {15'd0, DONE}, 16'd1);
        check("odd_err",  {15'd0, ERR},  16'd0);
        check("odd_mdb",  MDB_in,        16'h2345);
`endif
        tick();
        $display("txn odd_word_read 0x0203 done");

        // Reset mid-transaction, then a fresh read
        start(1'b1, 1'b0, 1'b0, 16'h0900, 16'h0000);
        check("rmid_req_before", {15'd0, mem_req}, 16'd1);
        rst_n = 1'b0;
        #1;
        check("rmid_req",  {15'd0, mem_req}, 16'd0);
        check("rmid_busy", {15'd0, BUSY},    16'd0);
        check("rmid_mdb",  MDB_in,           16'h0000);
        tick();
        rst_n = 1'b1;
        tick();
        check("rmid_nodone1", {15'd0, DONE}, 16'd0);
        tick();
        check("rmid_nodone2", {15'd0, DONE}, 16'd0);
        start(1'b1, 1'b0, 1'b0, 16'h0A00, 16'h0000);
        check("rnew_req",  {15'd0, mem_req}, 16'd1);
        check("rnew_addr", mem_addr,         16'h0A00);
        mem_ack   = 1'b1;
        mem_rdata = 16'h1234;
        tick();
        mem_ack = 1'b0;
        check("rnew_done", {15'd0, DONE}, 16'd1);
        check("rnew_err",  {15'd0, ERR},  16'd0);
        check("rnew_mdb",  MDB_in,        16'h1234);
        tick();
        $display("txn post_reset_read 0x0A00 MDB_in=%h", MDB_in);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
